// File: rtl/sigma_buffer_reader.sv
// Read-side controller for the sigma coefficient RAM: fetches a burst of
// coefficients and streams them out through a 2-entry skid FIFO.
module sigma_buffer_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              rden,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] coef_data,
  output logic              coef_valid,
  output logic              coef_last,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_r, cnt_r, last_addr;
  logic [ADDR_W:0]     issued_cnt, accepted_cnt, cnt_m1;
  logic                inflight;
  logic [DATA_W-1:0]   mem [0:1];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          fifo_cnt;
  logic [2:0]          occ;
  logic                pop, push, take;

  assign cnt_m1     = {1'b0, cnt_r} - (ADDR_W+1)'(1);
  assign coef_valid = fifo_cnt != 2'd0;
  assign pop        = coef_valid & coef_ready;
  assign push       = inflight;
  assign take       = start && (state == IDLE || state == FLUSH);
  assign busy       = (state == READ) || (state == DRAIN);
  assign done       = state == FLUSH;
  assign coef_data  = coef_valid ? mem[rd_ptr] : '0;
  assign coef_last  = coef_valid && (accepted_cnt == cnt_m1);

  // Credit: words already committed to the FIFO by the end of this cycle.
  // A read issued now lands a cycle later, so it needs that figure below 2.
  always_comb begin
    occ  = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    rden = (state == READ) && (occ < 3'd2);
  end

  assign rdaddress = rden ? base_r + issued_cnt[ADDR_W-1:0] : last_addr;

  // Data store needs no reset; occupancy and pointers define what is live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      base_r       <= '0;
      cnt_r        <= '0;
      last_addr    <= '0;
      issued_cnt   <= '0;
      accepted_cnt <= '0;
      inflight     <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      inflight <= rden;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr       <= ~rd_ptr;
        accepted_cnt <= accepted_cnt + (ADDR_W+1)'(1);
      end
      if (rden) begin
        last_addr  <= rdaddress;
        issued_cnt <= issued_cnt + (ADDR_W+1)'(1);
      end
      case (state)
        IDLE, FLUSH: begin
          state <= IDLE;
          if (take) begin
            base_r       <= base_addr;
            cnt_r        <= count;
            issued_cnt   <= '0;
            accepted_cnt <= '0;
            state        <= (count != '0) ? READ : FLUSH;
          end
        end
        READ:  if (rden && issued_cnt == cnt_m1) state <= DRAIN;
        DRAIN: if (pop && coef_last) state <= FLUSH;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigma_buffer_reader.sv
// Self-checking bench: table of bursts plus hand sequences, with a RAM model
// and a scoreboard of expected stream words and read addresses.
module tb_sigma_buffer_reader;
  logic       clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] base_addr = '0, count = '0, rdaddress, q = '0, coef_data;
  logic       rden, coef_valid, coef_last, coef_ready = 1'b0, busy, done;

  sigma_buffer_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .rden(rden), .rdaddress(rdaddress), .q(q),
    .coef_data(coef_data), .coef_valid(coef_valid), .coef_last(coef_last),
    .coef_ready(coef_ready), .busy(busy), .done(done));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
  always @(posedge clock) if (rden) q <= ram[rdaddress];

  int rdy_pct = 100;
  always @(posedge clock) begin
    #1 coef_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  typedef struct { logic [7:0] data; logic last; } word_t;
  word_t      sb[$];
  logic [7:0] exp_addr[$];

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: independent occupancy model, scoreboard pops, hold-stability.
  int tb_cnt = 0, tb_inf = 0, pop_cnt = 0, done_cnt = 0, done_cyc = 0;
  int first_rden = -1, first_valid = -1, c0 = 0;
  bit busy_seen = 0, hold = 0;
  logic [7:0] held_data;
  logic held_last;
  always @(negedge clock) begin
    if (reset) begin
      tb_cnt = 0; tb_inf = 0; hold = 0;
    end else begin
      automatic int pop = (coef_valid && coef_ready) ? 1 : 0;
      automatic word_t e;
      chk("valid_vs_occupancy", coef_valid, tb_cnt != 0);
      if (hold) begin
        chk("hold_valid", coef_valid, 1);
        chk("hold_data", coef_data, held_data);
        chk("hold_last", coef_last, held_last);
      end
      if (rden) begin
        if (first_rden < 0) first_rden = cyc;
        if (exp_addr.size() == 0) chk("spurious_rden", 1, 0);
        else chk("rdaddress", rdaddress, exp_addr.pop_front());
        chk("credit", (tb_cnt + tb_inf - pop) < 2, 1);
      end
      if (coef_valid && first_valid < 0) first_valid = cyc;
      if (pop != 0) begin
        pop_cnt++;
        if (sb.size() == 0) chk("spurious_word", 1, 0);
        else begin
          e = sb.pop_front();
          chk("coef_data", coef_data, e.data);
          chk("coef_last", coef_last, e.last);
        end
      end
      if (busy) busy_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_in_done", busy, 0);
      end
      tb_cnt = tb_cnt + tb_inf - pop;
      tb_inf = rden ? 1 : 0;
      hold = coef_valid && !coef_ready;
      held_data = coef_data;
      held_last = coef_last;
    end
  end

  // Drive start in the current cycle (T) and queue what the burst must produce.
  task automatic issue(input logic [7:0] b, input logic [7:0] n);
    logic [7:0] a;
    start = 1'b1; base_addr = b; count = n;
    c0 = cyc; first_rden = -1; first_valid = -1; busy_seen = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 8'(i);
      exp_addr.push_back(a);
      sb.push_back('{data: ram[a], last: (i == int'(n) - 1)});
    end
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input bit check_lat);
    int d0 = done_cnt, n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clock); #1 n++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    else if (check_lat) chk("done_latency", done_cyc - c0, exp_lat);
    chk("words_left", sb.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rden"}, rden, 0);
    chk({tag, "_rdaddress"}, rdaddress, 0);
    chk({tag, "_valid"}, coef_valid, 0);
    chk({tag, "_last"}, coef_last, 0);
    chk({tag, "_data"}, coef_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  typedef struct { logic [7:0] base; logic [7:0] cnt; int pct; int exp_lat; } vec_t;
  vec_t tbl[6];

  initial begin
    int d0, n, p0;
    tbl[0] = '{8'h10, 8'd4, 100, 7};
    tbl[1] = '{8'hFE, 8'd3, 100, 6};
    tbl[2] = '{8'h22, 8'd5, 50, -1};
    tbl[3] = '{8'h30, 8'd0, 100, 1};
    tbl[4] = '{8'h00, 8'd1, 100, 4};
    tbl[5] = '{8'h80, 8'd7, 30, -1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); check_idle("reset");

    foreach (tbl[k]) begin
      rdy_pct = tbl[k].pct;
      @(posedge clock); #1;
      issue(tbl[k].base, tbl[k].cnt);
      wait_done(tbl[k].exp_lat, tbl[k].exp_lat >= 0);
      if (tbl[k].pct == 100 && tbl[k].cnt != 0) begin
        chk("first_rden_lat", first_rden - c0, 1);
        chk("first_valid_lat", first_valid - c0, 3);
      end
      if (tbl[k].cnt == 0) begin
        chk("zero_busy_seen", busy_seen, 0);
        chk("zero_rden", first_rden, -1);
        chk("zero_valid", first_valid, -1);
      end
    end

    // start while busy must not disturb the running burst
    rdy_pct = 100;
    @(posedge clock); #1;
    issue(8'h60, 8'd6);
    @(posedge clock); #1 start = 1'b1; base_addr = 8'h00; count = 8'd9;
    @(posedge clock); #1 start = 1'b0;
    wait_done(9, 1);

    // reset mid-burst after two words
    @(posedge clock); #1;
    issue(8'h50, 8'd8);
    p0 = pop_cnt - 0; n = 0;
    p0 = pop_cnt;
    while (pop_cnt < p0 + 2 && n < 100) begin @(negedge clock); #1 n++; end
    chk("midburst_words", pop_cnt - p0, 2);
    p0 = pop_cnt;
    @(posedge clock); #1 reset = 1'b1;
    d0 = done_cnt;
    @(posedge clock); #1 reset = 1'b0;
    sb.delete(); exp_addr.delete();
    @(negedge clock); check_idle("abort");
    repeat (12) @(negedge clock);
    #1 chk("abort_no_done", done_cnt, d0);
    @(posedge clock); #1;
    issue(8'h40, 8'd2);
    wait_done(5, 1);

    // full-length burst with wrap, then a start in the done cycle
    @(posedge clock); #1;
    issue(8'h90, 8'd255);
    wait_done(258, 1);
    issue(8'h05, 8'd3);
    wait_done(6, 1);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
